// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline-stage register with valid/ready handshake and two-entry skid buffer
// Every output is decoded from flops, so in_ready never depends on out_ready in the same cycle.
module pipe_stage_reg #(
    parameter int unsigned           WIDTH     = 32,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               in_fire, out_fire;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // A word offered or consumed in the flush cycle is killed, not captured.
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and scoreboard bench for pipe_stage_reg
// Instance a is 32-bit with RESET_VAL DEADBEEF; instance b is 1-bit with RESET_VAL 1.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        clr, flush;
    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [31:0] in_data_a, out_data_a;
    logic [1:0]  occ_a;
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [0:0]  in_data_b, out_data_b;
    logic [1:0]  occ_b;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'hDEAD_BEEF)) u_a (
        .clk(clk), .clr(clr), .flush(flush),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .occupancy(occ_a)
    );

    pipe_stage_reg #(.WIDTH(1), .RESET_VAL(1'b1)) u_b (
        .clk(clk), .clr(clr), .flush(1'b0),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .occupancy(occ_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [31:0] d, input logic [1:0] occ,
                           input logic iv, input logic ov);
        check({tag, "_data"}, out_data_a, d);
        check({tag, "_occ"}, {30'd0, occ_a}, {30'd0, occ});
        check({tag, "_in_ready"}, {31'd0, in_ready_a}, {31'd0, iv});
        check({tag, "_out_valid"}, {31'd0, out_valid_a}, {31'd0, ov});
    endtask

    initial begin
        clr = 1'b0; flush = 1'b0;
        in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
        in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;

        // Asynchronous reset asserted mid-cycle, sampled before any edge.
        #3 clr = 1'b1;
        #1;
        check_a("reset_a", 32'hDEAD_BEEF, 2'd0, 1'b1, 1'b0);
        check("reset_b_data", {31'd0, out_data_b}, 32'd1);
        check("reset_b_occ", {30'd0, occ_b}, 32'd0);
        #8 clr = 1'b0;
        step();

        // Streaming at full rate.
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data_a = i;
            step();
            check_a($sformatf("stream_%0d", i), i, 2'd1, 1'b1, 1'b1);
        end
        in_valid_a = 1'b0;
        step();
        check_a("stream_drain", 32'd4, 2'd0, 1'b1, 1'b0);

        // Backpressure: 10 and 11 absorbed, 12 held upstream.
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        in_data_a   = 32'd10;
        step();
        check_a("bp_10", 32'd10, 2'd1, 1'b1, 1'b1);
        in_data_a = 32'd11;
        step();
        check_a("bp_11", 32'd10, 2'd2, 1'b0, 1'b1);
        in_data_a = 32'd12;
        step();
        check_a("bp_hold", 32'd10, 2'd2, 1'b0, 1'b1);
        out_ready_a = 1'b1;
        step();
        check_a("bp_rel_11", 32'd11, 2'd1, 1'b1, 1'b1);
        step();
        check_a("bp_rel_12", 32'd12, 2'd1, 1'b1, 1'b1);
        in_valid_a = 1'b0;
        step();
        check_a("bp_empty", 32'd12, 2'd0, 1'b1, 1'b0);

        // Flush while full with a coincident offer of 7.
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        in_data_a   = 32'd5;
        step();
        in_data_a = 32'd6;
        step();
        check_a("fl_full", 32'd5, 2'd2, 1'b0, 1'b1);
        flush = 1'b1; in_data_a = 32'd7; out_ready_a = 1'b1;
        step();
        flush = 1'b0; in_valid_a = 1'b0;
        check_a("fl_after", 32'hDEAD_BEEF, 2'd0, 1'b1, 1'b0);
        step();
        check_a("fl_no7", 32'hDEAD_BEEF, 2'd0, 1'b1, 1'b0);

        // Mid-cycle clr while full.
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        in_data_a   = 32'd20;
        step();
        in_data_a = 32'd21;
        step();
        in_valid_a = 1'b0;
        #2 clr = 1'b1;
        #1;
        check_a("clr_mid", 32'hDEAD_BEEF, 2'd0, 1'b1, 1'b0);
        clr = 1'b0;
        step();
        check_a("clr_post", 32'hDEAD_BEEF, 2'd0, 1'b1, 1'b0);

        // Randomised handshake against a FIFO scoreboard.
        sb_q.delete();
        for (int c = 0; c < 3000; c++) begin
            in_valid_a  = 1'($urandom_range(0, 1));
            out_ready_a = 1'($urandom_range(0, 2) != 0);
            in_data_a   = $urandom;
            check("rnd_occ", {30'd0, occ_a}, sb_q.size());
            check("rnd_in_ready", {31'd0, in_ready_a}, {31'd0, (sb_q.size() != 2)});
            if (out_valid_a && out_ready_a) begin
                if (sb_q.size() == 0) check("rnd_spurious", 32'd1, 32'd0);
                else check("rnd_order", out_data_a, sb_q.pop_front());
            end
            if (in_valid_a && in_ready_a) sb_q.push_back(in_data_a);
            step();
        end
        in_valid_a = 1'b0; out_ready_a = 1'b1;
        step(); step(); step();
        check("rnd_drained", {30'd0, occ_a}, 32'd0);

        // WIDTH=1 streaming.
        out_ready_b = 1'b1;
        in_valid_b  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] pat;
            pat = 4'b1101;
            in_data_b = pat[i];
            step();
            check($sformatf("w1_data_%0d", i), {31'd0, out_data_b}, {31'd0, pat[i]});
            check($sformatf("w1_occ_%0d", i), {30'd0, occ_b}, 32'd1);
        end
        in_valid_b = 1'b0;
        step();
        check("w1_empty", {31'd0, out_valid_b}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
